// File: rtl/inv_smix_pkg.sv
// Shared AES definitions for the decrypt datapath: widths, GF(2^8) helpers,
// the InvMixColumns column function and the inverse S-box table.
package inv_smix_pkg;

   localparam int COL_W     = 32;
   localparam int BYTE_W    = 8;
   localparam int NUM_LANES = COL_W / BYTE_W;
   localparam int IDX_W     = 2;

   localparam logic [8:0]        GF_POLY = 9'h11B;
   localparam logic [BYTE_W-1:0] GF_RED  = GF_POLY[BYTE_W-1:0];

   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
      return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_RED : '0);
   endfunction

   // InvMixColumns on one column; every product is built from the x2/x4/x8 chain.
   function automatic logic [COL_W-1:0] inv_mix_column(input logic [COL_W-1:0] col);
      logic [BYTE_W-1:0] a  [NUM_LANES];
      logic [BYTE_W-1:0] m9 [NUM_LANES];
      logic [BYTE_W-1:0] mb [NUM_LANES];
      logic [BYTE_W-1:0] md [NUM_LANES];
      logic [BYTE_W-1:0] me [NUM_LANES];
      logic [BYTE_W-1:0] x2, x4, x8;
      for (int k = 0; k < NUM_LANES; k++) begin
         a[k]  = col[COL_W-1-BYTE_W*k -: BYTE_W];
         x2    = xtime(a[k]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[k] = x8 ^ a[k];
         mb[k] = x8 ^ x2 ^ a[k];
         md[k] = x8 ^ x4 ^ a[k];
         me[k] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   localparam logic [BYTE_W-1:0] INV_SBOX_TBL [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/inv_smix_sbox.sv
// Combinational AES inverse S-box, one byte lane.
module inv_sbox
   import inv_smix_pkg::*;
(
   input  logic [BYTE_W-1:0] i_byte,
   output logic [BYTE_W-1:0] o_byte
);

   assign o_byte = INV_SBOX_TBL[i_byte];

endmodule

// File: rtl/inv_smix.sv
// Decrypt column engine: InvMixColumns (S1) then InvSubBytes (S2), valid/ready pipeline.
// Optional column-order checker enabled by INV_SMIX_SEQ_CHECK_EN.
module inv_smix
   import inv_smix_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [COL_W-1:0] word_in,
   input  logic [IDX_W-1:0] index,
   input  logic             first_round,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [COL_W-1:0] word_out,
   output logic [IDX_W-1:0] index_out,
   output logic             seq_err
);

   logic             r_s1_valid, r_s2_valid;
   logic [COL_W-1:0] r_s1_word,  r_s2_word;
   logic [IDX_W-1:0] r_s1_idx,   r_s2_idx;

   logic             w_adv1, w_adv2, w_accept;
   logic [COL_W-1:0] w_mix, w_sub;

   assign w_adv2   = ~r_s2_valid | out_ready;
   assign w_adv1   = ~r_s1_valid | w_adv2;
   assign w_accept = in_valid & w_adv1;
   assign in_ready = w_adv1;

   // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_mix = word_in;
      if (!first_round) w_mix = inv_mix_column(word_in);
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_sbox
      inv_sbox u_inv_sbox (
         .i_byte (r_s1_word[BYTE_W*g +: BYTE_W]),
         .o_byte (w_sub[BYTE_W*g +: BYTE_W])
      );
   end

   // NOTE: sequential state uses non-blocking assignments only, so every stage samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_word  <= '0;
         r_s1_idx   <= '0;
      end else if (w_adv1) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_word <= w_mix;
            r_s1_idx  <= index;
         end
      end
   end

   // S2 payload is reset because word_out/index_out must read 0 out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_word  <= '0;
         r_s2_idx   <= '0;
      end else if (w_adv2) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_word <= w_sub;
            r_s2_idx  <= r_s1_idx;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign word_out  = r_s2_word;
   assign index_out = r_s2_idx;

`ifdef INV_SMIX_SEQ_CHECK_EN
   logic [IDX_W-1:0] r_exp_idx;
   logic             r_seq_err;

   // Counter always resyncs to the received index so one bad column flags once, not forever.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp_idx <= '0;
         r_seq_err <= 1'b0;
      end else if (w_accept) begin
         r_exp_idx <= index + 1'b1;
         if (index != r_exp_idx) r_seq_err <= 1'b1;
      end
   end

   assign seq_err = r_seq_err;
`else
   logic w_unused;
   assign w_unused = w_accept;
   assign seq_err  = 1'b0;
`endif

endmodule

// File: tb/tb_inv_smix.sv
// Directed, table-driven bench for inv_smix (column transform, handshake, reset, order check).
module tb_inv_smix;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] word_in;
   logic [1:0]  index;
   logic        first_round;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] word_out;
   logic [1:0]  index_out;
   logic        seq_err;

   int total = 0;
   int bad   = 0;

`ifdef INV_SMIX_SEQ_CHECK_EN
   localparam logic SEQ_ON = 1'b1;
`else
   localparam logic SEQ_ON = 1'b0;
`endif

   typedef struct {
      logic [31:0] w;
      logic [1:0]  idx;
      logic        fr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [8];

   inv_smix dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .word_in     (word_in),
      .index       (index),
      .first_round (first_round),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .word_out    (word_out),
      .index_out   (index_out),
      .seq_err     (seq_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k);
      in_valid    = 1'b1;
      word_in     = vecs[k].w;
      index       = vecs[k].idx;
      first_round = vecs[k].fr;
   endtask

   initial begin
      int accepted;
      int k;
      logic rdy;

      vecs[0] = '{32'h8E4DA1BC, 2'd0, 1'b0, 32'h9F825068};
      vecs[1] = '{32'h63636363, 2'd1, 1'b1, 32'h00000000};
      vecs[2] = '{32'h00000000, 2'd2, 1'b0, 32'h52525252};
      vecs[3] = '{32'h9FDC589D, 2'd3, 1'b0, 32'h04A394A7};
      vecs[4] = '{32'h01010101, 2'd0, 1'b0, 32'h09090909};
      vecs[5] = '{32'hD5D5D7D6, 2'd1, 1'b0, 32'h191919B5};
      vecs[6] = '{32'h4D7EBDF8, 2'd2, 1'b0, 32'hFA232E5D};
      vecs[7] = '{32'h52096AD5, 2'd3, 1'b1, 32'h484058B5};

      rst_n = 1'b0; in_valid = 1'b0; word_in = '0; index = '0;
      first_round = 1'b0; out_ready = 1'b1;
      step(); step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_word_out",  word_out, 32'd0);
      check("rst_index_out", {30'd0, index_out}, 32'd0);
      check("rst_seq_err",   {31'd0, seq_err}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      #2 rst_n = 1'b1;
      step();

      // Single columns, unstalled: 2-cycle latency and transform per vector.
      for (int i = 0; i < 8; i++) begin
         drive(i);
         step();
         in_valid = 1'b0;
         check($sformatf("vec%0d_lat1_valid", i), {31'd0, out_valid}, 32'd0);
         step();
         check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("vec%0d_word", i),  word_out, vecs[i].exp);
         check($sformatf("vec%0d_index", i), {30'd0, index_out}, {30'd0, vecs[i].idx});
      end

      // Back-to-back stream at full throughput.
      for (int c = 0; c < 10; c++) begin
         if (c < 8) drive(c);
         else       in_valid = 1'b0;
         step();
         if (c == 0 || c == 9) begin
            check($sformatf("stream_c%0d_idle", c), {31'd0, out_valid}, 32'd0);
         end else begin
            check($sformatf("stream_c%0d_valid", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("stream_c%0d_word", c),  word_out, vecs[c-1].exp);
            check($sformatf("stream_c%0d_index", c), {30'd0, index_out}, {30'd0, vecs[c-1].idx});
         end
      end
      check("empty_word_hold", word_out, vecs[7].exp);
      check("stream_seq_err",  {31'd0, seq_err}, 32'd0);

      // Backpressure: three columns offered with out_ready low.
      out_ready = 1'b0;
      accepted  = 0;
      for (int a = 0; a < 4; a++) begin
         k = (accepted > 2) ? 2 : accepted;
         drive(k);
         rdy = in_ready;
         step();
         if (rdy) accepted++;
      end
      check("bp_accepted",  accepted, 32'd2);
      check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_word",      word_out, vecs[0].exp);
      step();
      check("bp_word_stable",  word_out, vecs[0].exp);
      check("bp_index_stable", {30'd0, index_out}, 32'd0);
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_out1_word",  word_out, vecs[1].exp);
      check("bp_out1_index", {30'd0, index_out}, 32'd1);
      step();
      check("bp_out2_word",  word_out, vecs[2].exp);
      check("bp_out2_index", {30'd0, index_out}, 32'd2);
      step();
      check("bp_drained", {31'd0, out_valid}, 32'd0);

      // Column-order checker: indices 0,2,3,0 after a fresh reset.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      drive(0); step();
      check("seq_after_0", {31'd0, seq_err}, 32'd0);
      drive(2); step();
      check("seq_after_2", {31'd0, seq_err}, {31'd0, SEQ_ON});
      drive(3); step();
      check("seq_after_3", {31'd0, seq_err}, {31'd0, SEQ_ON});
      drive(4); step();
      in_valid = 1'b0;
      check("seq_sticky", {31'd0, seq_err}, {31'd0, SEQ_ON});
      step(); step();

      // Reset with both stages full.
      out_ready = 1'b0;
      drive(1); step();
      drive(2); step();
      in_valid = 1'b0;
      check("full_out_valid", {31'd0, out_valid}, 32'd1);
      check("full_in_ready",  {31'd0, in_ready}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_word",      word_out, 32'd0);
      check("midrst_seq_err",   {31'd0, seq_err}, 32'd0);
      check("midrst_in_ready",  {31'd0, in_ready}, 32'd1);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      check("postrst_idle", {31'd0, out_valid}, 32'd0);
      drive(3); step();
      in_valid = 1'b0;
      check("postrst_lat1", {31'd0, out_valid}, 32'd0);
      step();
      check("postrst_valid", {31'd0, out_valid}, 32'd1);
      check("postrst_word",  word_out, vecs[3].exp);
      check("postrst_index", {30'd0, index_out}, 32'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
